axi4_mem_slave: RTL

AXI4_MEM_SLAVE -- requirements
Module: axi4_mem_slave

---
 rtl/axi4_mem_slave.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_mem_slave.sv
// ============================================================================
// Module   : axi4_mem_slave
// Brief    : AXI4 INCR-burst memory slave with independent read/write FSMs.
//            Optional ready/valid stall insertion via AXI_MEM_BACKPRESSURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_mem_slave #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH          = 4096,
    parameter int RD_LATENCY         = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic                            wlast_err
);

    localparam int         c_IDX_W  = $clog2(MEM_DEPTH);
    localparam int         c_NB     = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [3:0] c_LAT_M1 = 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rstate_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wstate_t                       wstate_q, wstate_d;
    logic [c_IDX_W-1:0]            widx_q, widx_d;
    logic [7:0]                    awlen_q, awlen_d;
    logic [7:0]                    wbeat_q, wbeat_d;
    logic                          wlast_err_q, wlast_err_d;

    rstate_t                       rstate_q, rstate_d;
    logic [c_IDX_W-1:0]            ridx_q, ridx_d;
    logic [7:0]                    arlen_q, arlen_d;
    logic [7:0]                    rbeat_q, rbeat_d;
    logic [3:0]                    rcnt_q, rcnt_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                          w_aw_gate, w_w_gate, w_ar_gate, w_rv_gate;
    logic                          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [c_IDX_W-1:0]            w_wr_idx, w_rd_load_idx;
    logic                          w_rd_load;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_word;
    logic                          w_unused_addr;

`ifdef AXI_MEM_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end

    assign w_aw_gate = lfsr_q[0];
    assign w_w_gate  = lfsr_q[1];
    assign w_ar_gate = lfsr_q[2];
    assign w_rv_gate = lfsr_q[3];
`else
    assign w_aw_gate = 1'b1;
    assign w_w_gate  = 1'b1;
    assign w_ar_gate = 1'b1;
    assign w_rv_gate = 1'b1;
`endif

    // All outputs forced inactive while rst is high, not just after the edge
    assign s_axi_awready = !rst && (wstate_q == W_IDLE) && w_aw_gate;
    assign s_axi_wready  = !rst && (wstate_q == W_DATA) && w_w_gate;
    assign s_axi_bvalid  = !rst && (wstate_q == W_RESP);
    assign s_axi_arready = !rst && (rstate_q == R_IDLE) && w_ar_gate;
    assign s_axi_rvalid  = !rst && (rstate_q == R_DATA);
    assign s_axi_rlast   = s_axi_rvalid && (rbeat_q == arlen_q);
    assign s_axi_rdata   = rst ? '0 : rdata_q;
    assign wlast_err     = !rst && wlast_err_q;

    assign w_aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
    assign w_b_hs  = s_axi_bvalid  && s_axi_bready;
    assign w_ar_hs = s_axi_arvalid && s_axi_arready;
    assign w_r_hs  = s_axi_rvalid  && s_axi_rready;

    assign w_wr_idx      = widx_q + c_IDX_W'(wbeat_q);
    assign w_unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    always_comb begin
        wstate_d    = wstate_q;
        widx_d      = widx_q;
        awlen_d     = awlen_q;
        wbeat_d     = wbeat_q;
        wlast_err_d = wlast_err_q;
        case (wstate_q)
            W_IDLE: begin
                if (w_aw_hs) begin
                    widx_d   = s_axi_awaddr[2 +: c_IDX_W];
                    awlen_d  = s_axi_awlen;
                    wbeat_d  = '0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_w_hs) begin
                    wbeat_d = wbeat_q + 8'd1;
                    // Beat count, not wlast, ends the burst
                    if (wbeat_q == awlen_q) begin
                        wstate_d = W_RESP;
                        if (!s_axi_wlast) wlast_err_d = 1'b1;
                    end else if (s_axi_wlast) begin
                        wlast_err_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (w_b_hs) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d      = rstate_q;
        ridx_d        = ridx_q;
        arlen_d       = arlen_q;
        rbeat_d       = rbeat_q;
        rcnt_d        = rcnt_q;
        w_rd_load     = 1'b0;
        w_rd_load_idx = ridx_q + c_IDX_W'(rbeat_q);
        case (rstate_q)
            R_IDLE: begin
                if (w_ar_hs) begin
                    ridx_d  = s_axi_araddr[2 +: c_IDX_W];
                    arlen_d = s_axi_arlen;
                    rbeat_d = '0;
                    rcnt_d  = c_LAT_M1;
                    if ((RD_LATENCY == 1) && w_rv_gate) begin
                        rstate_d      = R_DATA;
                        w_rd_load     = 1'b1;
                        w_rd_load_idx = s_axi_araddr[2 +: c_IDX_W];
                    end else begin
                        rstate_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rcnt_q > 4'd1) begin
                    rcnt_d = rcnt_q - 4'd1;
                end else if (w_rv_gate) begin
                    rcnt_d    = '0;
                    rstate_d  = R_DATA;
                    w_rd_load = 1'b1;
                end
            end
            R_DATA: begin
                if (w_r_hs) begin
                    if (rbeat_q == arlen_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rbeat_d       = rbeat_q + 8'd1;
                        w_rd_load     = 1'b1;
                        w_rd_load_idx = ridx_q + c_IDX_W'(rbeat_q + 8'd1);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase

        // Forward a same-edge write so the captured beat is never one write stale
        w_rd_word = mem[w_rd_load_idx];
        for (int b = 0; b < c_NB; b++) begin
            if (w_w_hs && s_axi_wstrb[b] && (w_wr_idx == w_rd_load_idx)) begin
                w_rd_word[8*b +: 8] = s_axi_wdata[8*b +: 8];
            end
        end
        rdata_d = w_rd_load ? w_rd_word : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q    <= W_IDLE;
            widx_q      <= '0;
            awlen_q     <= '0;
            wbeat_q     <= '0;
            wlast_err_q <= 1'b0;
            rstate_q    <= R_IDLE;
            ridx_q      <= '0;
            arlen_q     <= '0;
            rbeat_q     <= '0;
            rcnt_q      <= '0;
            rdata_q     <= '0;
        end else begin
            wstate_q    <= wstate_d;
            widx_q      <= widx_d;
            awlen_q     <= awlen_d;
            wbeat_q     <= wbeat_d;
            wlast_err_q <= wlast_err_d;
            rstate_q    <= rstate_d;
            ridx_q      <= ridx_d;
            arlen_q     <= arlen_d;
            rbeat_q     <= rbeat_d;
            rcnt_q      <= rcnt_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage is deliberately outside reset so contents survive rst
    always_ff @(posedge clk) begin
        for (int b = 0; b < c_NB; b++) begin
            if (w_w_hs && s_axi_wstrb[b]) begin
                mem[w_wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

endmodule

`default_nettype wire
